// File: rtl/u409_autoconfig_pkg.sv
// Shared types and constants for the U409 autoconfig responder:
// board/bus state encodings, config ROM offsets and board register values.
package u409_autoconfig_pkg;

  typedef enum logic [1:0] {BOARD0, BOARD1, DONE} board_t;
  typedef enum logic [1:0] {BUS_IDLE, BUS_WAIT, BUS_ACK} bus_t;

  localparam logic [7:0] OFF_TYPE    = 8'h00;
  localparam logic [7:0] OFF_PROD    = 8'h04;
  localparam logic [7:0] OFF_FLAGS   = 8'h08;
  localparam logic [7:0] OFF_MFG_HI  = 8'h10;
  localparam logic [7:0] OFF_MFG_LO  = 8'h14;
  localparam logic [7:0] OFF_BASE_Z3 = 8'h44;
  localparam logic [7:0] OFF_BASE_HI = 8'h48;
  localparam logic [7:0] OFF_BASE_LO = 8'h4A;
  localparam logic [7:0] OFF_SHUTUP  = 8'h4C;

  localparam logic [7:0] TYPE0  = 8'h8D;
  localparam logic [7:0] FLAGS0 = 8'h30;
  localparam logic [7:0] TYPE1  = 8'hC1;
  localparam logic [7:0] FLAGS1 = 8'h00;

endpackage

// File: rtl/u409_autoconfig_rom.sv
// Config ROM lookup: (board, offset) -> nibble for D[31:28].
// Every register except er_Type is returned inverted; holes read as $F.
module u409_autoconfig_rom
  import u409_autoconfig_pkg::*;
#(
  parameter logic [15:0] MFG_ID = 16'h082C,
  parameter logic [7:0]  PROD0  = 8'h01,
  parameter logic [7:0]  PROD1  = 8'h02
) (
  input  board_t      board,
  input  logic [7:1]  offset,
  output logic [3:0]  nibble
);

  logic [7:0] reg_off;
  logic [7:0] reg_byte;
  logic       hit;
  logic [3:0] raw;

  // Register byte R sits at R (high nibble) and R+2 (low nibble).
  always_comb begin
    reg_off  = {offset[7:2], 2'b00};
    reg_byte = 8'h00;
    hit      = 1'b0;
    if (board == BOARD0) begin
      case (reg_off)
        OFF_TYPE:   begin reg_byte = TYPE0;         hit = 1'b1; end
        OFF_PROD:   begin reg_byte = PROD0;         hit = 1'b1; end
        OFF_FLAGS:  begin reg_byte = FLAGS0;        hit = 1'b1; end
        OFF_MFG_HI: begin reg_byte = MFG_ID[15:8];  hit = 1'b1; end
        OFF_MFG_LO: begin reg_byte = MFG_ID[7:0];   hit = 1'b1; end
        default:    ;
      endcase
    end else if (board == BOARD1) begin
      case (reg_off)
        OFF_TYPE:   begin reg_byte = TYPE1;         hit = 1'b1; end
        OFF_PROD:   begin reg_byte = PROD1;         hit = 1'b1; end
        OFF_FLAGS:  begin reg_byte = FLAGS1;        hit = 1'b1; end
        OFF_MFG_HI: begin reg_byte = MFG_ID[15:8];  hit = 1'b1; end
        OFF_MFG_LO: begin reg_byte = MFG_ID[7:0];   hit = 1'b1; end
        default:    ;
      endcase
    end
    raw = offset[1] ? reg_byte[3:0] : reg_byte[7:4];
    if (!hit)
      nibble = 4'hF;
    else if (reg_off == OFF_TYPE)
      nibble = raw;
    else
      nibble = ~raw;
  end

endmodule

// File: rtl/u409_autoconfig.sv
// Autoconfig responder for the PCI memory window (board 0) and bridge
// register space (board 1): window decode, ROM reads, base writes, TA timing.
module u409_autoconfig
  import u409_autoconfig_pkg::*;
#(
  parameter logic [15:0] MFG_ID    = 16'h082C,
  parameter logic [7:0]  PROD0     = 8'h01,
  parameter logic [7:0]  PROD1     = 8'h02,
  parameter int unsigned WAIT_CLKS = 2
) (
  input  logic        CLK40,
  input  logic        RESETn,
  input  logic [31:0] A,
  input  logic        TSn,
  input  logic        RnW,
  input  logic [7:0]  D_IN,
  output logic [3:0]  D_OUT,
  output logic        D_OEn,
  output logic        TAn,
  output logic        TA_OEn,
  output logic        AUTOCONFIG_SPACE,
  output logic [7:0]  PCI_BASE,
  output logic        PCI_CONFIGED,
  output logic [7:0]  REG_BASE,
  output logic        REG_CONFIGED
);

  board_t     board_state, board_next;
  bus_t       bus_state, bus_next;
  logic [2:0] wait_cnt;
  logic [7:1] off_lat;
  logic       rnw_lat;
  logic [7:0] off_byte;
  logic       commit_write;
  logic [3:0] rom_nibble;
  logic       unused_addr;

  assign unused_addr      = ^{A[15:8], A[0]};
  assign AUTOCONFIG_SPACE = (A[31:16] == 16'h00E8) && (board_state != DONE);
  assign off_byte         = {off_lat, 1'b0};
  assign commit_write     = (bus_state == BUS_ACK) && !rnw_lat;

  u409_autoconfig_rom #(
    .MFG_ID (MFG_ID),
    .PROD0  (PROD0),
    .PROD1  (PROD1)
  ) u_rom (
    .board  (board_state),
    .offset (off_lat),
    .nibble (rom_nibble)
  );

  always_comb begin
    bus_next = bus_state;
    case (bus_state)
      BUS_IDLE: if (!TSn && AUTOCONFIG_SPACE) bus_next = BUS_WAIT;
      BUS_WAIT: if (wait_cnt == 3'(WAIT_CLKS)) bus_next = BUS_ACK;
      BUS_ACK:  bus_next = BUS_IDLE;
      default:  bus_next = BUS_IDLE;
    endcase
  end

  // Board advances only on a write that completes its ack clock.
  always_comb begin
    board_next = board_state;
    if (commit_write) begin
      case (board_state)
        BOARD0:  if (off_byte == OFF_BASE_Z3 || off_byte == OFF_SHUTUP) board_next = BOARD1;
        BOARD1:  if (off_byte == OFF_BASE_HI || off_byte == OFF_SHUTUP) board_next = DONE;
        default: board_next = board_state;
      endcase
    end
  end

  // TA outputs are registered from the next bus state; the clock after ACK
  // keeps TA_OEn low to actively drive TAn back high.
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      bus_state <= BUS_IDLE;
      wait_cnt  <= 3'd0;
      off_lat   <= 7'd0;
      rnw_lat   <= 1'b1;
      TAn       <= 1'b1;
      TA_OEn    <= 1'b1;
      D_OEn     <= 1'b1;
      D_OUT     <= 4'h0;
    end else begin
      bus_state <= bus_next;
      TAn       <= !(bus_next == BUS_ACK);
      TA_OEn    <= !((bus_next == BUS_ACK) || (bus_state == BUS_ACK));
      D_OEn     <= !((bus_state == BUS_WAIT) && rnw_lat);
      wait_cnt  <= (bus_state == BUS_WAIT) ? wait_cnt + 3'd1 : 3'd0;
      if (bus_state == BUS_WAIT)
        D_OUT <= rom_nibble;
      if (bus_state == BUS_IDLE && bus_next == BUS_WAIT) begin
        off_lat <= A[7:1];
        rnw_lat <= RnW;
      end
    end
  end

  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      board_state  <= BOARD0;
      PCI_BASE     <= 8'h00;
      PCI_CONFIGED <= 1'b0;
      REG_BASE     <= 8'h00;
      REG_CONFIGED <= 1'b0;
    end else begin
      board_state <= board_next;
      if (commit_write) begin
        if (board_state == BOARD0 && off_byte == OFF_BASE_Z3) begin
          PCI_BASE     <= D_IN;
          PCI_CONFIGED <= 1'b1;
        end
        if (board_state == BOARD1 && off_byte == OFF_BASE_LO)
          REG_BASE[3:0] <= D_IN[7:4];
        if (board_state == BOARD1 && off_byte == OFF_BASE_HI) begin
          REG_BASE[7:4] <= D_IN[7:4];
          REG_CONFIGED  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_u409_autoconfig.sv
// Self-checking bench for u409_autoconfig: directed sequence with random
// offsets, checked against a register-table model of the two boards.
module tb_u409_autoconfig;

  localparam logic [15:0] MFG = 16'h082C;
  localparam logic [7:0]  P0  = 8'h01;
  localparam logic [7:0]  P1  = 8'h02;
  localparam int          W   = 2;

  logic        clk = 1'b0;
  logic        RESETn, TSn, RnW;
  logic [31:0] A;
  logic [7:0]  D_IN;
  logic [3:0]  D_OUT;
  logic        D_OEn, TAn, TA_OEn, AUTOCONFIG_SPACE;
  logic [7:0]  PCI_BASE, REG_BASE;
  logic        PCI_CONFIGED, REG_CONFIGED;

  int checks = 0;
  int errors = 0;

  int         m_board;
  logic [7:0] m_pci_base, m_reg_base;
  logic       m_pci_cfg, m_reg_cfg;
  logic [3:0] last_dout;

  always #5 clk = ~clk;

  u409_autoconfig #(
    .MFG_ID(MFG), .PROD0(P0), .PROD1(P1), .WAIT_CLKS(W)
  ) dut (
    .CLK40(clk), .RESETn(RESETn), .A(A), .TSn(TSn), .RnW(RnW), .D_IN(D_IN),
    .D_OUT(D_OUT), .D_OEn(D_OEn), .TAn(TAn), .TA_OEn(TA_OEn),
    .AUTOCONFIG_SPACE(AUTOCONFIG_SPACE),
    .PCI_BASE(PCI_BASE), .PCI_CONFIGED(PCI_CONFIGED),
    .REG_BASE(REG_BASE), .REG_CONFIGED(REG_CONFIGED)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Board register table: byte at R (high nibble) and R+2 (low nibble),
  // inverted except er_Type, anything else reads $F.
  function automatic logic [3:0] model_nibble(input int brd, input logic [7:0] off);
    logic [7:0] roff [5];
    logic [7:0] rval [5];
    logic [15:0] mfg;
    logic [3:0] n;
    mfg = MFG;
    roff = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14};
    if (brd == 0) rval = '{8'h8D, P0, 8'h30, mfg[15:8], mfg[7:0]};
    else          rval = '{8'hC1, P1, 8'h00, mfg[15:8], mfg[7:0]};
    model_nibble = 4'hF;
    if (brd < 2) begin
      for (int i = 0; i < 5; i++) begin
        if (off == roff[i] || off == roff[i] + 8'd2) begin
          n = (off == roff[i]) ? rval[i][7:4] : rval[i][3:0];
          model_nibble = (i == 0) ? n : ~n;
        end
      end
    end
  endfunction

  task automatic model_reset();
    m_board = 0; m_pci_base = 8'h00; m_reg_base = 8'h00;
    m_pci_cfg = 1'b0; m_reg_cfg = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] off, input logic [7:0] din);
    if (m_board == 0 && off == 8'h44) begin
      m_pci_base = din; m_pci_cfg = 1'b1; m_board = 1;
    end else if (m_board == 1 && off == 8'h4A) begin
      m_reg_base[3:0] = din[7:4];
    end else if (m_board == 1 && off == 8'h48) begin
      m_reg_base[7:4] = din[7:4]; m_reg_cfg = 1'b1; m_board = 2;
    end else if (off == 8'h4C && m_board < 2) begin
      m_board = m_board + 1;
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_pci_base"}, 32'(PCI_BASE), 32'(m_pci_base));
    checkOutput({tag, "_pci_cfg"}, 32'(PCI_CONFIGED), 32'(m_pci_cfg));
    checkOutput({tag, "_reg_base"}, 32'(REG_BASE), 32'(m_reg_base));
    checkOutput({tag, "_reg_cfg"}, 32'(REG_CONFIGED), 32'(m_reg_cfg));
    checkOutput({tag, "_acs"}, 32'(AUTOCONFIG_SPACE),
                32'((A[31:16] == 16'h00E8) && (m_board < 2)));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_dout"}, 32'(D_OUT), 0);
    checkOutput({tag, "_doe"}, 32'(D_OEn), 1);
    checkOutput({tag, "_ta"}, 32'(TAn), 1);
    checkOutput({tag, "_taoe"}, 32'(TA_OEn), 1);
    checkState(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    RESETn = 1'b0; TSn = 1'b1;
    repeat (2) @(negedge clk);
    RESETn = 1'b1;
    model_reset();
  endtask

  // One full autoconfig bus cycle, checked clock by clock after edge N.
  task automatic applyStimulus(input logic [31:0] addr, input logic rnw, input logic [7:0] din);
    logic [7:0] off;
    off = {addr[7:1], 1'b0};
    A = addr; RnW = rnw; D_IN = din; TSn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    TSn = 1'b1;
    checkOutput("k0_ta", 32'(TAn), 1);
    checkOutput("k0_doe", 32'(D_OEn), 1);
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (k == 1) TSn = 1'($urandom);
      if (k == 2) TSn = 1'b1;
      if (k <= W) begin
        checkOutput("wait_ta", 32'(TAn), 1);
        checkOutput("wait_taoe", 32'(TA_OEn), 1);
        checkOutput("wait_doe", 32'(D_OEn), 32'(!rnw));
      end else if (k == W + 1) begin
        checkOutput("ack_ta", 32'(TAn), 0);
        checkOutput("ack_taoe", 32'(TA_OEn), 0);
        checkOutput("ack_doe", 32'(D_OEn), 32'(!rnw));
        last_dout = D_OUT;
        if (rnw) checkOutput("ack_dout", 32'(D_OUT), 32'(model_nibble(m_board, off)));
      end else if (k == W + 2) begin
        if (!rnw) model_write(off, din);
        checkOutput("neg_ta", 32'(TAn), 1);
        checkOutput("neg_taoe", 32'(TA_OEn), 0);
        checkOutput("neg_doe", 32'(D_OEn), 1);
        checkState("post");
      end else begin
        checkOutput("rel_taoe", 32'(TA_OEn), 1);
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return {16'h00E8, 8'($urandom), 7'($urandom_range(0, 127)), 1'($urandom)};
  endfunction

  initial begin
    logic [31:0] addr;
    RESETn = 1'b0; TSn = 1'b1; A = 32'h00E80000; RnW = 1'b1; D_IN = 8'h00;
    last_dout = 4'h0;
    model_reset();
    $display("[TB] start");

    doReset();
    checkResetValues("rst");
    checkOutput("rst_acs_const", 32'(AUTOCONFIG_SPACE), 1);

    applyStimulus(32'h00E80000, 1'b1, 8'h00);
    checkOutput("rd00_const", 32'(last_dout), 32'h8);
    applyStimulus(32'h00E80002, 1'b1, 8'h00);
    checkOutput("rd02_const", 32'(last_dout), 32'hD);
    applyStimulus(32'h00E80010, 1'b1, 8'h00);
    checkOutput("rd10_const", 32'(last_dout), 32'hF);

    for (int i = 0; i < 8; i++) applyStimulus(rand_addr(), 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      addr = rand_addr();
      if (addr[7:1] == 7'h22 || addr[7:1] == 7'h26) addr[7:0] = 8'h40;
      applyStimulus(addr, 1'b0, 8'($urandom));
    end

    applyStimulus(32'h00E80044, 1'b0, 8'hAB);
    checkOutput("pci_base_const", 32'(PCI_BASE), 32'hAB);
    checkOutput("pci_cfg_const", 32'(PCI_CONFIGED), 1);
    applyStimulus(32'h00E80000, 1'b1, 8'h00);
    checkOutput("b1_rd00_const", 32'(last_dout), 32'hC);
    for (int i = 0; i < 6; i++) applyStimulus(rand_addr(), 1'b1, 8'h00);

    applyStimulus(32'h00E8004A, 1'b0, 8'h50);
    applyStimulus(32'h00E80048, 1'b0, 8'hE0);
    checkOutput("reg_base_const", 32'(REG_BASE), 32'hE5);
    checkOutput("reg_cfg_const", 32'(REG_CONFIGED), 1);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      A = (i % 2 == 0) ? rand_addr() : $urandom;
      #1 checkState("done");
    end

    // A TS in DONE must not be answered.
    A = 32'h00E80000; RnW = 1'b1; TSn = 1'b0;
    @(negedge clk);
    TSn = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      checkOutput("done_no_ta", 32'(TAn), 1);
      checkOutput("done_no_doe", 32'(D_OEn), 1);
    end

    doReset();
    A = 32'h00E90000; TSn = 1'b0;
    @(negedge clk);
    TSn = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      checkOutput("nowin_no_ta", 32'(TAn), 1);
    end

    applyStimulus(32'h00E8004C, 1'b0, 8'hFF);
    checkOutput("shut0_cfg", 32'(PCI_CONFIGED), 0);
    applyStimulus(32'h00E80000, 1'b1, 8'h00);
    checkOutput("shut0_b1", 32'(last_dout), 32'hC);
    applyStimulus(32'h00E8004C, 1'b0, 8'hFF);
    checkOutput("shut1_cfg", 32'(REG_CONFIGED), 0);
    checkOutput("shut1_acs", 32'(AUTOCONFIG_SPACE), 0);

    doReset();
    applyStimulus(32'h00E80044, 1'b0, 8'h5A);
    A = 32'h00E80002; RnW = 1'b1; TSn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    TSn = 1'b1;
    @(negedge clk);
    checkOutput("abort_doe_pre", 32'(D_OEn), 0);
    RESETn = 1'b0;
    @(negedge clk);
    model_reset();
    checkResetValues("abort");
    RESETn = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      checkOutput("abort_no_ta", 32'(TAn), 1);
      checkOutput("abort_no_taoe", 32'(TA_OEn), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
